// File: rtl/soc_system_clk_gen.sv
// Multi-channel divided-clock and clock-enable generator with a lock sequencer and a
// valid/ready reconfiguration port. Optional relock counter port: CLK_GEN_RELOCK_CNT_EN.
module soc_system_clk_gen #(
  parameter int unsigned                 NUM_CLOCKS  = 2,
  parameter int unsigned                 DIV_W       = 8,
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DIV_INIT    = {8'd5, 8'd1},
  parameter int unsigned                 LOCK_CYCLES = 16,
  parameter int unsigned                 SEL_W       = 4
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [DIV_W-1:0]      cfg_div,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
`ifdef CLK_GEN_RELOCK_CNT_EN
  ,
  output logic [15:0]           relock_count
`endif
);

  localparam int unsigned       LOCK_EFF  = (LOCK_CYCLES == 0) ? 1 : LOCK_CYCLES;
  localparam int unsigned       LCNT_W    = (LOCK_EFF > 1) ? $clog2(LOCK_EFF) : 1;
  localparam int unsigned       IDX_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;
  localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_EFF - 1);

  typedef enum logic [1:0] {S_WAIT, S_LOCKED, S_APPLY, S_RELOCK} state_e;

  state_e            state_q;
  logic [LCNT_W-1:0] lock_cnt_q;
  logic              locked_q;
  logic              cfg_ready_q;
  logic              cfg_err_q;
  logic [IDX_W-1:0]  sel_q;
  logic [DIV_W-1:0]  div_cap_q;
  logic [DIV_W-1:0]  div_q [NUM_CLOCKS];

  logic sel_ok;
  logic accept;

  assign sel_ok = (32'(cfg_sel) < NUM_CLOCKS);
  assign accept = (state_q == S_LOCKED) && cfg_valid && cfg_ready_q && sel_ok;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      sel_q       <= '0;
      div_cap_q   <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        S_WAIT, S_RELOCK: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_q     <= S_LOCKED;
            locked_q    <= 1'b1;
            cfg_ready_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCNT_W'(1);
          end
        end
        S_LOCKED: begin
          if (accept) begin
            sel_q       <= IDX_W'(cfg_sel);
            div_cap_q   <= cfg_div;
            state_q     <= S_APPLY;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
          end else if (cfg_valid && cfg_ready_q) begin
            cfg_err_q <= 1'b1;
          end
        end
        S_APPLY: begin
          for (int i = 0; i < NUM_CLOCKS; i++)
            if (sel_q == IDX_W'(i)) div_q[i] <= div_cap_q;
          lock_cnt_q <= '0;
          state_q    <= S_RELOCK;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  // A zero divisor behaves as divide-by-one, so its terminal count is also zero.
  logic [DIV_W-1:0]      div_last [NUM_CLOCKS];
  logic [DIV_W-1:0]      cnt_q    [NUM_CLOCKS];
  logic [DIV_W-1:0]      cnt_d    [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] en_q, en_d;
  logic [NUM_CLOCKS-1:0] clk_q, clk_d;

  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++)
      div_last[i] = (div_q[i] == '0) ? '0 : div_q[i] - DIV_W'(1);
  end

  always_comb begin
    cnt_d = cnt_q;
    en_d  = '0;
    clk_d = clk_q;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (!locked_q) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
      end else if (cnt_q[i] == div_last[i]) begin
        cnt_d[i] = '0;
        en_d[i]  = 1'b1;
        clk_d[i] = ~clk_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLOCKS; i++) cnt_q[i] <= '0;
      en_q  <= '0;
      clk_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
      clk_q <= clk_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign locked    = locked_q;
  assign outclk_en = en_q;
  assign outclk    = clk_q;

`ifdef CLK_GEN_RELOCK_CNT_EN
  logic [15:0] relock_cnt_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt_q <= '0;
    end else if (accept && (relock_cnt_q != 16'hFFFF)) begin
      relock_cnt_q <= relock_cnt_q + 16'd1;
    end
  end

  assign relock_count = relock_cnt_q;
`else
  // No relock counter in this build.
`endif

endmodule
